itcm_arbiter: RTL and testbench
===============================

Name: itcm_arbiter

Overview:
- Shares the single-port, synchronous-read ITCM between two requesters: the instruction-fetch stage and the data-side load/store/loader port from execution.
- Sits between the fetch/execution units and the itcm macro. Decides per-cycle ownership of the memory port and steers read data back to the correct requester one cycle later.
- Data side has priority. A starvation counter guarantees fetch forward progress.

Parameters:
- ADDR_W, 32, byte address width of both request ports.
- MEM_AW, 14, word address width of the ITCM (16K words).
- MAX_STARVE, 4, number of consecutive denied fetch cycles after which fetch is forced to win.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch requests a read this cycle.
- if_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  32  fetch read data.
- d_req  in  1  data-side request this cycle.
- d_we  in  1  1 = write, 0 = read.
- d_be  in  4  byte enables for writes.
- d_addr  in  ADDR_W  data byte address; bits [1:0] ignored.
- d_wdata  in  32  write data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data read data valid (reads only).
- d_rdata  out  32  data read data.
- mem_en  out  1  ITCM access enable.
- mem_we  out  4  ITCM byte write strobes.
- mem_addr  out  MEM_AW  ITCM word address.
- mem_wdata  out  32  ITCM write data.
- mem_rdata  in  32  ITCM read data, valid the cycle after a read enable.

Behaviour:
- Grant logic is combinational, in the same cycle as the request; at most one grant per cycle.
  - Only one requester active: that requester is granted.
  - Both active and starve_cnt < MAX_STARVE: data is granted.
  - Both active and starve_cnt == MAX_STARVE: fetch is granted.
- starve_cnt: ceil(log2(MAX_STARVE+1)) bits, reset value 0.
  - Increments when if_req=1 and if_gnt=0.
  - Clears when if_gnt=1 or if_req=0.
  - Saturates at MAX_STARVE and never wraps.
- Memory drive:
  - mem_en = if_gnt | d_gnt.
  - mem_addr = granted address [MEM_AW+1:2].
  - mem_we = d_be when d_gnt & d_we, else 0.
  - mem_wdata = d_wdata.
  - Address bits above MEM_AW+1 are ignored, so accesses alias.
- Response owner register owner_q ∈ {OWN_NONE, OWN_IF, OWN_D}, reset OWN_NONE. Next value:
  - OWN_IF if fetch was granted.
  - OWN_D if a data read was granted.
  - OWN_NONE otherwise, including granted writes.
- Read latency is exactly 1 cycle.
  - if_rvalid = (owner_q == OWN_IF).
  - d_rvalid = (owner_q == OWN_D).
  - Each rdata equals mem_rdata when its rvalid is 1, else 32'h0.
- Writes complete at grant and produce no rvalid.
- Back-to-back: a new grant may be issued in the same cycle that the previous read's rvalid is asserted, giving full throughput of 1 access/cycle.
- Requesters hold req/addr/data stable until gnt. The arbiter does not register requests.
- Reset asserted mid-operation: owner_q returns to OWN_NONE and starve_cnt to 0 immediately, so any pending rvalid is dropped. While reset is low, all grants and mem_en are 0.
- Reset values of all outputs are 0: if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_en, mem_we, mem_addr, mem_wdata.

Decomposition:
- Shared package itcm_arb_pkg contains:
  - owner_e enum {OWN_NONE, OWN_IF, OWN_D}.
  - Default MAX_STARVE and MEM_AW constants.
  - OWN_* encodings, reused by the future debug loader.
- Optional sub-module itcm_starve_cnt: the saturating starvation counter with a force output. All else stays in itcm_arbiter.

Test Plan:
- Fetch only: if_req=1 at if_addr 0x0000_0010 with mem preloaded 0xDEAD_BEEF at word 4 -> if_gnt same cycle, mem_addr=4; next cycle if_rvalid=1, if_rdata=0xDEAD_BEEF, d_rvalid=0.
- Data write then read: d_we=1, d_be=4'b0011, d_addr=0x20, d_wdata=0x1234_5678 -> mem_we=4'b0011, no d_rvalid. Following read of 0x20 -> d_rvalid next cycle with low half 0x5678.
- Contention: if_req and d_req held high for 10 cycles, MAX_STARVE=4 -> data granted cycles 0-3, fetch granted cycle 4, starve_cnt back to 0, pattern repeats (fetch at cycles 4 and 9).
- Simultaneous response/grant: fetch read cycle N, data read cycle N+1 -> cycle N+1 shows if_rvalid=1 and d_gnt=1; cycle N+2 shows d_rvalid=1 and if_rvalid=0.
- Reset mid-read: fetch granted, then reset driven low before the next clock edge -> if_rvalid stays 0, all outputs 0, starve_cnt 0. After release, first request behaves as in scenario 1.
- Alias/misalign: d_addr=0x0001_0023 (MEM_AW=14) read -> mem_addr=0x0008, low address bits ignored, response on the d_ side only.

Source files
------------

// File: rtl/itcm_arb_pkg.sv
// rtl/itcm_arb_pkg.sv - shared types and defaults for the ITCM arbiter
package itcm_arb_pkg;

  localparam int DEF_MAX_STARVE = 4;
  localparam int DEF_MEM_AW     = 14;

  // Owner of the read response returning next cycle; encodings are shared
  // with the debug loader, so keep the values stable.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Who receives the read data launched by this cycle's grant.
  function automatic owner_e next_owner(input logic if_gnt, input logic d_gnt, input logic d_we);
    if (if_gnt) begin
      return OWN_IF;
    end else if (d_gnt && !d_we) begin
      return OWN_D;
    end
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/itcm_starve_cnt.sv
// rtl/itcm_starve_cnt.sv - saturating count of consecutive denied fetch cycles
module itcm_starve_cnt
  import itcm_arb_pkg::*;
#(
  parameter int MAX_STARVE = DEF_MAX_STARVE
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic if_req_i,
  input  logic if_gnt_i,
  output logic force_o
);

  localparam int              CW    = $clog2(MAX_STARVE + 1);
  localparam logic [CW-1:0]   MAX_C = CW'(MAX_STARVE);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count only while fetch is asking and losing; any grant or idle clears it.
  always_comb begin
    cnt_d = '0;
    if (if_req_i && !if_gnt_i) begin
      cnt_d = (cnt_q == MAX_C) ? MAX_C : cnt_q + 1'b1;
    end
  end

  // Counter register, cleared immediately by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_o = (cnt_q == MAX_C);

endmodule

// File: rtl/itcm_arbiter.sv
// rtl/itcm_arbiter.sv - fetch/data arbiter for the single-port synchronous ITCM
module itcm_arbiter
  import itcm_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int MEM_AW     = DEF_MEM_AW,
  parameter int MAX_STARVE = DEF_MAX_STARVE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic              starve_force;
  logic              fetch_wins;
  logic [MEM_AW-1:0] if_waddr;
  logic [MEM_AW-1:0] d_waddr;
  owner_e            owner_q;
  owner_e            owner_d;

  // Upper address bits alias into the ITCM and the byte offset is dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[ADDR_W-1:MEM_AW+2], if_addr[1:0],
                              d_addr[ADDR_W-1:MEM_AW+2], d_addr[1:0]};

  assign if_waddr = if_addr[MEM_AW+1:2];
  assign d_waddr  = d_addr[MEM_AW+1:2];

  // Data side wins contention unless fetch has been starved long enough.
  assign fetch_wins = if_req & (~d_req | starve_force);
  assign if_gnt     = reset & fetch_wins;
  assign d_gnt      = reset & d_req & ~fetch_wins;

  itcm_starve_cnt #(
    .MAX_STARVE (MAX_STARVE)
  ) u_starve_cnt (
    .clk_i    (clk),
    .rst_ni   (reset),
    .if_req_i (if_req),
    .if_gnt_i (if_gnt),
    .force_o  (starve_force)
  );

  // Steer the winning request onto the memory port; idle port drives zeros.
  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = reset ? d_wdata : '0;
    if (if_gnt) begin
      mem_addr = if_waddr;
    end else if (d_gnt) begin
      mem_addr = d_waddr;
      if (d_we) begin
        mem_we = d_be;
      end
    end
  end

  // Remember which requester owns the read data arriving next cycle.
  always_comb begin
    owner_d = next_owner(if_gnt, d_gnt, d_we);
  end

  // Owner register; reset drops any response still in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign if_rvalid = (owner_q == OWN_IF);
  assign d_rvalid  = (owner_q == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
  assign d_rdata   = d_rvalid  ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_itcm_arbiter.sv
// tb/tb_itcm_arbiter.sv - self-checking bench for itcm_arbiter
module tb_itcm_arbiter;

  localparam int MAX_STARVE = 4;
  localparam int MEM_AW     = 14;

  logic              clk;
  logic              reset;
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  int checks = 0;
  int errors = 0;

  itcm_arbiter #(
    .ADDR_W     (32),
    .MEM_AW     (MEM_AW),
    .MAX_STARVE (MAX_STARVE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Initial ITCM image, used by both the macro emulation and the reference.
  function automatic logic [31:0] init_word(input int idx);
    if (idx == 4) return 32'hDEAD_BEEF;
    if (idx == 8) return 32'hCAFE_F00D;
    return 32'h1000_0000 + idx;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                        input logic [31:0] data);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) w[8*b +: 8] = data[8*b +: 8];
    end
    return w;
  endfunction

  // ---------------- ITCM macro emulation (environment) ----------------
  logic [31:0] macro_mem [int];

  function automatic logic [31:0] macro_read(input int idx);
    return macro_mem.exists(idx) ? macro_mem[idx] : init_word(idx);
  endfunction

  task automatic macro_write(input int idx, input logic [3:0] be, input logic [31:0] data);
    macro_mem[idx] = merge(macro_read(idx), be, data);
  endtask

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we != 4'b0) macro_write(int'(mem_addr), mem_we, mem_wdata);
      else mem_rdata <= macro_read(int'(mem_addr));
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [int];
  int          streak;
  int          resp_who;
  logic [31:0] resp_data;
  logic        exp_fg;
  logic        exp_dg;

  function automatic logic [31:0] ref_read(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
  endfunction

  task automatic ref_write(input int idx, input logic [3:0] be, input logic [31:0] data);
    ref_mem[idx] = merge(ref_read(idx), be, data);
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[MEM_AW+1:2]);
  endfunction

  assign exp_fg = reset && if_req && (!d_req || streak >= MAX_STARVE);
  assign exp_dg = reset && d_req && !exp_fg;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak    <= 0;
      resp_who  <= 0;
      resp_data <= '0;
    end else begin
      if (if_req && !exp_fg) streak <= (streak < MAX_STARVE) ? streak + 1 : streak;
      else streak <= 0;
      if (exp_fg) begin
        resp_who  <= 1;
        resp_data <= ref_read(widx(if_addr));
      end else if (exp_dg && !d_we) begin
        resp_who  <= 2;
        resp_data <= ref_read(widx(d_addr));
      end else begin
        resp_who  <= 0;
        resp_data <= '0;
      end
      if (exp_dg && d_we) ref_write(widx(d_addr), d_be, d_wdata);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("if_gnt", if_gnt, exp_fg);
    chk("d_gnt", d_gnt, exp_dg);
    chk("mem_en", mem_en, exp_fg | exp_dg);
    chk("mem_we", mem_we, (exp_dg && d_we) ? d_be : 4'b0);
    chk("mem_addr", mem_addr, exp_fg ? if_addr[MEM_AW+1:2] : (exp_dg ? d_addr[MEM_AW+1:2] : '0));
    chk("mem_wdata", mem_wdata, reset ? d_wdata : 32'h0);
    chk("if_rvalid", if_rvalid, resp_who == 1);
    chk("d_rvalid", d_rvalid, resp_who == 2);
    chk("if_rdata", if_rdata, (resp_who == 1) ? resp_data : 32'h0);
    chk("d_rdata", d_rdata, (resp_who == 2) ? resp_data : 32'h0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_be    = 4'b0;
    d_addr  = '0;
    d_wdata = '0;
  endtask

  logic [9:0] pat10;
  logic [4:0] pat5;

  initial begin
    reset = 1'b0;
    idle_inputs();
    if_req  = 1'b1;
    d_req   = 1'b1;
    d_wdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("rst_if_gnt", if_gnt, 1'b0);
    chk("rst_d_gnt", d_gnt, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    tick();
    tick();
    idle_inputs();
    reset = 1'b1;
    tick();

    // Fetch only
    if_req  = 1'b1;
    if_addr = 32'h0000_0010;
    @(negedge clk);
    chk("s1_if_gnt", if_gnt, 1'b1);
    chk("s1_mem_addr", mem_addr, 14'd4);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("s1_if_rvalid", if_rvalid, 1'b1);
    chk("s1_if_rdata", if_rdata, 32'hDEAD_BEEF);
    chk("s1_d_rvalid", d_rvalid, 1'b0);
    tick();

    // Data write then read back
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_be    = 4'b0011;
    d_addr  = 32'h20;
    d_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("s2_mem_we", mem_we, 4'b0011);
    chk("s2_d_gnt", d_gnt, 1'b1);
    tick();
    d_we = 1'b0;
    d_be = 4'b0;
    @(negedge clk);
    chk("s2_no_rvalid_wr", d_rvalid, 1'b0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("s2_d_rvalid", d_rvalid, 1'b1);
    chk("s2_d_rdata_lo", {16'h0, d_rdata[15:0]}, 32'h0000_5678);
    chk("s2_d_rdata", d_rdata, 32'hCAFE_5678);
    tick();

    // Contention for 10 cycles
    if_req  = 1'b1;
    if_addr = 32'h10;
    d_req   = 1'b1;
    d_addr  = 32'h20;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pat10[i] = if_gnt;
      tick();
    end
    chk("s3_fetch_pattern", {22'h0, pat10}, 32'b10_0001_0000);
    idle_inputs();
    tick();

    // Fetch read then data read: response and grant overlap
    if_req  = 1'b1;
    if_addr = 32'h10;
    @(negedge clk);
    tick();
    idle_inputs();
    d_req  = 1'b1;
    d_addr = 32'h20;
    @(negedge clk);
    chk("s4_if_rvalid", if_rvalid, 1'b1);
    chk("s4_d_gnt", d_gnt, 1'b1);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("s4_d_rvalid", d_rvalid, 1'b1);
    chk("s4_if_rvalid_off", if_rvalid, 1'b0);
    chk("s4_d_rdata", d_rdata, 32'hCAFE_5678);
    tick();

    // Reset during an in-flight fetch read
    if_req  = 1'b1;
    if_addr = 32'h10;
    @(negedge clk);
    chk("s5_if_gnt", if_gnt, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("s5_if_gnt_rst", if_gnt, 1'b0);
    chk("s5_mem_en_rst", mem_en, 1'b0);
    chk("s5_mem_addr_rst", mem_addr, 14'd0);
    tick();
    chk("s5_if_rvalid_rst", if_rvalid, 1'b0);
    chk("s5_if_rdata_rst", if_rdata, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("s5_post_if_gnt", if_gnt, 1'b1);
    chk("s5_post_mem_addr", mem_addr, 14'd4);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("s5_post_if_rdata", if_rdata, 32'hDEAD_BEEF);
    tick();

    // Starvation count is cleared by reset
    if_req = 1'b1;
    d_req  = 1'b1;
    d_addr = 32'h20;
    tick();
    tick();
    @(negedge clk);
    #2 reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pat5[i] = if_gnt;
      tick();
    end
    chk("s5_starve_after_rst", {27'h0, pat5}, 32'b1_0000);
    idle_inputs();
    tick();

    // Aliased, misaligned data read
    d_req  = 1'b1;
    d_addr = 32'h0001_0023;
    @(negedge clk);
    chk("s6_mem_addr", mem_addr, 14'h0008);
    chk("s6_d_gnt", d_gnt, 1'b1);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("s6_d_rvalid", d_rvalid, 1'b1);
    chk("s6_if_rvalid", if_rvalid, 1'b0);
    chk("s6_d_rdata", d_rdata, 32'hCAFE_5678);
    tick();

    // Mixed traffic over a small aliased window, checked by the model
    for (int i = 0; i < 60; i++) begin
      if_req  = 1'($urandom_range(0, 1));
      if_addr = {$urandom_range(0, 3) << 16} | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      d_req   = 1'($urandom_range(0, 1));
      d_we    = ($urandom_range(0, 3) == 0);
      d_be    = 4'($urandom_range(0, 15));
      d_addr  = {$urandom_range(0, 3) << 16} | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      d_wdata = $urandom;
      tick();
    end
    idle_inputs();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
